// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-ported 64-bit data memory between two requesters.
// Optional macro DMEM_ARB_RR_EN: round-robin arbitration instead of fixed priority.
module dmem_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            req_valid,
   output logic [1:0]            req_ready,
   input  logic [1:0]            req_we,
   input  logic [2*ADDR_W-1:0]   req_addr,
   input  logic [4*DATA_W-1:0]   req_wdata,
   output logic [1:0]            rsp_valid,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  mem_re,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata
);

   typedef enum logic [2:0] {
      IDLE, RD, RDW, WR0, WR1, DONE
   } state_e;

   localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_e              state_q;
   logic                owner_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   whi_q;
   logic [1:0]          rsp_valid_q;
   logic [DATA_W-1:0]   rsp_rdata_q;
   logic                mem_re_q;
   logic                mem_we_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;

   logic [1:0]          grant;
   logic                gid;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [2*DATA_W-1:0] sel_wdata;

`ifdef DMEM_ARB_RR_EN
   logic ptr_q;
   logic ptr_d;
`endif

   // Grant one valid requester, only while idle.
   always_comb begin
      grant = 2'b00;
      if (state_q == IDLE) begin
`ifdef DMEM_ARB_RR_EN
         if (req_valid == 2'b11) grant = ptr_q ? 2'b10 : 2'b01;
         else                    grant = req_valid;
`else
         if (req_valid[0])      grant = 2'b01;
         else if (req_valid[1]) grant = 2'b10;
`endif
      end
   end

   // Mux the granted requester's fields.
   always_comb begin
      gid       = grant[1];
      sel_we    = gid ? req_we[1] : req_we[0];
      sel_addr  = gid ? req_addr[ADDR_W +: ADDR_W]
                      : req_addr[0 +: ADDR_W];
      sel_wdata = gid ? req_wdata[2*DATA_W +: 2*DATA_W]
                      : req_wdata[0 +: 2*DATA_W];
   end

   assign req_ready = grant;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign mem_re    = mem_re_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

   // Transaction sequencer with registered memory and response outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         addr_q      <= '0;
         whi_q       <= '0;
         rsp_valid_q <= 2'b00;
         rsp_rdata_q <= '0;
         mem_re_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         rsp_valid_q <= 2'b00;
         mem_re_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (grant != 2'b00) begin
                  owner_q    <= gid;
                  addr_q     <= sel_addr;
                  whi_q      <= sel_wdata[2*DATA_W-1:DATA_W];
                  mem_addr_q <= sel_addr;
                  if (sel_we) begin
                     state_q     <= WR0;
                     mem_we_q    <= 1'b1;
                     mem_wdata_q <= sel_wdata[DATA_W-1:0];
                  end else begin
                     state_q  <= RD;
                     mem_re_q <= 1'b1;
                  end
               end
            end
            RD: state_q <= RDW;
            RDW: begin
               rsp_rdata_q <= mem_rdata;
               rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
               state_q     <= DONE;
            end
            WR0: begin
               mem_we_q    <= 1'b1;
               mem_addr_q  <= addr_q + ONE;
               mem_wdata_q <= whi_q;
               state_q     <= WR1;
            end
            WR1: begin
               rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
               state_q     <= DONE;
            end
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef DMEM_ARB_RR_EN
   assign ptr_d = ~gid;

   // Hand priority to the other requester after every acceptance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= 1'b0;
      else if (grant != 2'b00) ptr_q <= ptr_d;
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random transactions against a
// word-level memory model and transaction-level expectations.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   req_valid;
   logic [1:0]   req_ready;
   logic [1:0]   req_we;
   logic [15:0]  req_addr;
   logic [255:0] req_wdata;
   logic [1:0]   rsp_valid;
   logic [63:0]  rsp_rdata;
   logic         mem_re;
   logic         mem_we;
   logic [7:0]   mem_addr;
   logic [63:0]  mem_wdata;
   logic [63:0]  mem_rdata = '0;

   logic [63:0]  mem [256] = '{default: '0};
   logic [63:0]  ref_mem [256];
   logic [63:0]  last_rdata;
   logic         exp_ptr;
   int           nvec = 0;
   int           nerr = 0;
   int           cyc = 0;

   dmem_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .mem_re    (mem_re),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Single-port memory, one-cycle read latency.
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
   end

   task automatic chk(input string tag,
                      input logic [127:0] obs,
                      input logic [127:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) chk("excl", {127'b0, mem_re & mem_we}, '0);
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // One full transaction: accept, two beats, response, back to idle.
   task automatic do_req(input bit id, input bit we,
                         input logic [7:0] a,
                         input logic [127:0] wd,
                         input bit oth);
      int n;
      logic [1:0] oh;
      logic [7:0] a1;
      logic [63:0] exp_rd;
      oh = id ? 2'b10 : 2'b01;
      a1 = 8'((int'(a) + 1) % 256);
      req_valid = oh;
      req_we[id] = we;
      if (id) begin
         req_addr[15:8] = a;
         req_wdata[255:128] = wd;
      end else begin
         req_addr[7:0] = a;
         req_wdata[127:0] = wd;
      end
      #1;
      n = 0;
      while (req_ready == 2'b00 && n < 16) begin
         @(posedge clk); #1;
         n++;
      end
      chk("accept", {126'b0, req_ready}, {126'b0, oh});
      exp_ptr = ~id;
      // cycle 1
      @(posedge clk); #1;
      chk("c1_re", {127'b0, mem_re}, {127'b0, ~we});
      chk("c1_we", {127'b0, mem_we}, {127'b0, we});
      chk("c1_addr", {120'b0, mem_addr}, {120'b0, a});
      if (we) chk("c1_wdata", {64'b0, mem_wdata}, {64'b0, wd[63:0]});
      chk("c1_rsp", {126'b0, rsp_valid}, '0);
      req_valid = oth ? ~oh : 2'b00;
      req_wdata = ~req_wdata;
      req_addr = ~req_addr;
      #1;
      chk("busy_ready1", {126'b0, req_ready}, '0);
      // cycle 2
      @(posedge clk); #1;
      chk("c2_re", {127'b0, mem_re}, '0);
      chk("c2_we", {127'b0, mem_we}, {127'b0, we});
      if (we) begin
         chk("c2_addr", {120'b0, mem_addr}, {120'b0, a1});
         chk("c2_wdata", {64'b0, mem_wdata}, {64'b0, wd[127:64]});
      end
      chk("c2_rsp", {126'b0, rsp_valid}, '0);
      chk("busy_ready2", {126'b0, req_ready}, '0);
      // cycle 3
      @(posedge clk); #1;
      exp_rd = we ? last_rdata : ref_mem[a];
      chk("c3_rsp", {126'b0, rsp_valid}, {126'b0, oh});
      chk("c3_rdata", {64'b0, rsp_rdata}, {64'b0, exp_rd});
      chk("c3_memidle", {126'b0, mem_re, mem_we}, '0);
      chk("busy_ready3", {126'b0, req_ready}, '0);
      last_rdata = exp_rd;
      if (we) begin
         ref_mem[a] = wd[63:0];
         ref_mem[a1] = wd[127:64];
      end
      // cycle 4: idle again
      @(posedge clk); #1;
      chk("c4_rsp", {126'b0, rsp_valid}, '0);
      if (oth) chk("idle_ready", {126'b0, req_ready}, {126'b0, ~oh});
      req_valid = 2'b00;
      #1;
   endtask

   initial begin
      logic [7:0] pool [7];
      int n;
      int last_acc;
      bit eid;
      logic [7:0] ca0, ca1;
      pool = '{8'h10, 8'h11, 8'h12, 8'hFE, 8'hFF, 8'h00, 8'h01};
      for (int i = 0; i < 256; i++) ref_mem[i] = '0;
      last_rdata = '0;
      exp_ptr = 1'b0;
      rst = 1'b1;
      req_valid = '0;
      req_we = '0;
      req_addr = '0;
      req_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rsp", {126'b0, rsp_valid}, '0);
      chk("rst_mem", {55'b0, mem_re, mem_we, mem_addr, mem_wdata}, '0);
      chk("rst_rdata", {64'b0, rsp_rdata}, '0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Store then load, requester 0.
      do_req(1'b0, 1'b1, 8'h10, {64'hBBBB, 64'hAAAA}, 1'b0);
      do_req(1'b0, 1'b0, 8'h11, '0, 1'b1);
      chk("ld_bbbb", {64'b0, rsp_rdata}, 128'hBBBB);

      // Wrap from the top word to word 0.
      do_req(1'b1, 1'b1, 8'hFF, {64'h1234, 64'h5678}, 1'b1);
      do_req(1'b1, 1'b0, 8'h00, '0, 1'b0);
      do_req(1'b0, 1'b0, 8'hFF, '0, 1'b0);

      // Reset during the first store beat.
      req_valid = 2'b01;
      req_we = 2'b01;
      req_addr[7:0] = 8'h10;
      req_wdata[127:0] = {64'hDEAD, 64'hBEEF};
      #1;
      chk("rst_acc", {126'b0, req_ready}, 128'h1);
      @(posedge clk); #1;
      req_valid = 2'b00;
      chk("wr0_pre", {127'b0, mem_we}, 128'h1);
      rst = 1'b1;
      #1;
      chk("rst_async_mem", {55'b0, mem_re, mem_we, mem_addr, mem_wdata}, '0);
      chk("rst_async_rsp", {126'b0, rsp_valid}, '0);
      chk("rst_async_rd", {64'b0, rsp_rdata}, '0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("rst_hold_rsp", {126'b0, rsp_valid}, '0);
      end
      rst = 1'b0;
      last_rdata = '0;
      exp_ptr = 1'b0;
      @(posedge clk); #1;
      do_req(1'b0, 1'b0, 8'h10, '0, 1'b0);
      chk("ld_aaaa", {64'b0, rsp_rdata}, 128'hAAAA);

      // Contention: both requesters loading continuously.
      ca0 = 8'h11;
      ca1 = 8'h00;
      req_we = 2'b00;
      req_addr = {ca1, ca0};
      req_valid = 2'b11;
      #1;
      last_acc = 0;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         while (req_ready == 2'b00 && n < 8) begin
            @(posedge clk); #1;
            n++;
         end
         eid = RR ? exp_ptr : 1'b0;
         chk("cont_grant", {126'b0, req_ready},
             eid ? 128'h2 : 128'h1);
         if (k > 0) chk("cont_gap", 128'(cyc - last_acc), 128'd4);
         last_acc = cyc;
         exp_ptr = ~eid;
         repeat (3) begin
            @(posedge clk); #1;
         end
         chk("cont_rsp", {126'b0, rsp_valid}, eid ? 128'h2 : 128'h1);
         chk("cont_rd", {64'b0, rsp_rdata},
             {64'b0, ref_mem[eid ? ca1 : ca0]});
         last_rdata = ref_mem[eid ? ca1 : ca0];
         @(posedge clk); #1;
      end
      req_valid = 2'b00;
      #1;

      // Random transactions.
      for (int t = 0; t < 40; t++) begin
         logic [7:0] ra;
         ra = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                         : pool[$urandom_range(0, 6)];
         do_req(1'($urandom), 1'($urandom), ra,
                {32'($urandom), 32'($urandom),
                 32'($urandom), 32'($urandom)},
                1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single-ported, 64-bit-wide data memory between two requesters.
- Requester 0 is the load/store stage; requester 1 is the debug/loader port.
- Each granted request becomes memory beats: a 1-beat read, or a 2-beat 128-bit store (low word at addr, high word at addr+1).
- Sits between the pipeline MEM stage and the data memory; replaces direct enable-strobed access with a clocked handshake.

Parameters:
- ADDR_W, 8, word-address width; memory depth is 2^ADDR_W 64-bit words.
- DATA_W, 64, memory word width; store payload is 2*DATA_W.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester request valid, bit i = requester i.
- req_ready  out  2  per-requester accept; transfer when valid&ready.
- req_we  in  2  1 = 128-bit store, 0 = 64-bit load.
- req_addr  in  2*ADDR_W  word address; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  4*DATA_W  store data; requester i at [i*2*DATA_W +: 2*DATA_W].
- rsp_valid  out  2  one-cycle completion pulse to the owning requester.
- rsp_rdata  out  DATA_W  load data, valid with rsp_valid for a load.
- mem_re  out  1  memory read strobe; data returns the next cycle.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, 1-cycle latency after mem_re.

Behaviour:
- Reset (async, any state): FSM -> IDLE; rsp_valid=0, rsp_rdata=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0; latched request cleared; priority pointer -> requester 0.
- FSM states:
  - IDLE -> RD (load accepted) or WR0 (store accepted).
  - RD -> RDW.
  - RDW -> DONE.
  - WR0 -> WR1.
  - WR1 -> DONE.
  - DONE -> IDLE.
- req_ready is combinational: only in IDLE, at most one bit set, on the granted valid requester. It is never asserted without req_valid.
- Acceptance edge: latch owner id, we, addr, 128-bit wdata. Requester inputs are ignored after acceptance.
- RD: mem_re=1, mem_addr=addr.
- RDW: mem_re=0; capture mem_rdata into rsp_rdata.
- WR0: mem_we=1, mem_addr=addr, mem_wdata=wdata[63:0].
- WR1: mem_we=1, mem_addr=addr+1 mod 2^ADDR_W (addr all-ones wraps to 0), mem_wdata=wdata[127:64].
- DONE: rsp_valid[owner]=1 for exactly one cycle. For a store, rsp_rdata holds its previous value.
- Latency:
  - Accept edge = cycle 0.
  - Memory beats occur in cycles 1–2.
  - rsp_valid high in cycle 3 for both loads and stores.
  - Next accept possible at earliest in cycle 4 (IDLE); peak throughput is 1 request per 4 cycles.
- mem_re and mem_we are never both high. All mem_* outputs are registered.
- Arbitration: with both valid in IDLE, fixed priority to requester 0 (see Optional Feature).
- A requester may deassert req_valid before acceptance; there is no penalty.
- Reset mid-operation aborts the transaction; no rsp_valid is issued. A half-completed store (WR0 done, WR1 not) leaves memory partially written; this is accepted behaviour.
- The response path has no backpressure; requesters must sample rsp_valid.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined: round-robin arbitration with a 1-bit pointer.
  - On each acceptance the pointer moves to the other requester.
  - With both valid, the pointer's requester wins.
  - With one valid, that requester wins regardless of the pointer.
- Undefined: fixed priority, requester 0 always wins, no pointer register.

Test Plan:
- Reset: assert rst mid-WR0 -> all outputs 0 immediately; FSM in IDLE; no rsp_valid; next request accepted normally after deassert.
- Store then load, requester 0: store addr=0x10, wdata={0xBBBB,0xAAAA} -> mem_we cycle1 addr 0x10 data 0xAAAA, cycle2 addr 0x11 data 0xBBBB; rsp_valid[0] cycle3. Then load addr 0x11 -> rsp_rdata=0xBBBB with rsp_valid[0].
- Wrap: store addr=0xFF -> second beat mem_addr=0x00.
- Contention: both requesters valid continuously, each issuing loads.
  - Fixed: only requester 0 accepted, 1 starves.
  - DMEM_ARB_RR_EN: grants alternate 0,1,0,1; one accept every 4 cycles.
- Handshake: requester 1 valid while busy -> req_ready=0 until IDLE; wdata changed after accept does not alter the written words.
- Exclusivity/latency check: mem_re&mem_we never both high; each rsp_valid is a one-cycle pulse exactly 3 cycles after its accept edge.
